player_sprite_seq: RTL
======================

# player_sprite_seq

Sequencer for the player sprite ROMs. It decides each frame which sprite set (forward, walk-left, walk-right, shoot) and which animation frame the player shows, and it generates the per-pixel ROM address and in-sprite flag for the current VGA pixel. It sits between the game-logic player registers and the sprite ROM/palette pipeline, replacing the full-screen stretch addressing with a positioned 43x50 sprite.

## Interface
- SPR_W, 43, sprite width in pixels
- SPR_H, 50, sprite height in pixels
- ANIM_DIV, 6, video frames per walk-animation toggle (1..63)
- SHOOT_FRAMES, 10, video frames the shoot pose is held (1..63)
- vga_clk  in  1  pixel clock; all state on posedge
- Reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- frame_start  in  1  one-cycle pulse at start of vertical blank
- move_left, move_right, shoot  in  1 each  level requests from keyboard logic
- PlayerX, PlayerY  in  10 each  top-left corner of the sprite, screen pixels
- DrawX, DrawY  in  10 each  current pixel from the VGA controller
- blank  in  1  high = visible region
- sprite_sel  out  2  0 FWD, 1 LEFT, 2 RIGHT, 3 SHOOT; steers the ROM/palette mux
- anim_frame  out  1  walk frame index
- rom_address  out  13  address into the selected ROM
- in_sprite  out  1  current pixel lies inside the sprite box and blank is high

## Operation
- The FSM has 4 states: FWD, LEFT, RIGHT, SHOOT. sprite_sel equals the state encoding.
- State changes only on a cycle with frame_start=1. Inputs are sampled on that cycle, so no pose change happens mid-frame.
- Next state from FWD, LEFT or RIGHT, in priority order:
  - shoot=1 → SHOOT.
  - Otherwise, exactly one of move_left or move_right high → LEFT or RIGHT.
  - Otherwise, both or neither high → FWD.
- On entry to SHOOT, the hold counter loads SHOOT_FRAMES-1. Each subsequent frame_start decrements it. At frame_start with the counter at 0, the next state follows the rules above, so shoot can re-enter SHOOT.
- shoot while in SHOOT with the counter non-zero is ignored (no retrigger). Movement is also ignored while in SHOOT.
- Animation counter (6 bits):
  - Increments on each frame_start while in LEFT or RIGHT.
  - On reaching ANIM_DIV-1 it wraps to 0 and toggles anim_frame.
  - On any transition into FWD or SHOOT, the counter and anim_frame clear to 0.
  - LEFT↔RIGHT transitions keep both values.
- Box test: dx=DrawX-PlayerX and dy=DrawY-PlayerY, computed as 11-bit signed. The pixel is inside when 0≤dx<SPR_W and 0≤dy<SPR_H, and blank=1. Sprites clipped at the screen edge need no special case.
- Address:
  - Base = dy*SPR_W + dx, unsigned 13-bit; max 2149 at the defaults.
  - In LEFT or RIGHT with anim_frame=1, add SPR_W*SPR_H (2150); max 4299.
  - In FWD and SHOOT the offset is always 0.
  - When not inside the box, rom_address=0.
- Reset values: state FWD, sprite_sel=0, anim_frame=0, counters 0, rom_address=0, in_sprite=0.
- Reset asserted mid-frame or mid-shoot returns everything to these values immediately (asynchronously). The next frame_start after release evaluates from FWD.

## Timing
- FSM, counters and anim_frame update on the posedge where frame_start=1. The new sprite_sel is visible the cycle after.
- rom_address and in_sprite are registered, giving 1 cycle latency from DrawX/DrawY/blank. They use the state as it was before that edge.
- The ROM samples rom_address on the following negedge of vga_clk, and q is valid before the next posedge. The consumer registers palette colour gated by in_sprite delayed 1 cycle, for 2 cycles total from pixel coordinates.
- frame_start coinciding with a visible pixel is legal. The address for that pixel uses the old state.
- The multiply is SPR_W constant × dy; it must close timing at 25 MHz in one cycle.

## Test plan
- Reset release, no inputs, pixel at (PlayerX,PlayerY)=(100,200) → one cycle later in_sprite=1, rom_address=0, sprite_sel=0.
- DrawX=142, DrawY=249 with Player (100,200) → rom_address=2149. DrawX=143 → in_sprite=0, rom_address=0. PlayerX=5, DrawX=2 → in_sprite=0 (negative dx).
- Hold move_right, issue 13 frame_start pulses with ANIM_DIV=6 → sprite_sel=2 after pulse 1. anim_frame toggles 0→1 at pulse 7 and back to 0 at pulse 13, since the counter starts at the RIGHT entry. Address at dx=dy=0 is 2150 while anim_frame=1.
- Pulse shoot together with move_left at a frame_start → SHOOT. Shoot pressed again during the hold is ignored, and the state stays SHOOT for exactly 10 frame_starts. With move_left still high it then goes to LEFT with anim_frame=0.
- move_left and move_right both high → FWD. Change inputs with no frame_start → sprite_sel unchanged.
- Assert Reset mid-shoot and mid-line → all outputs 0 within the same cycle. Release, then frame_start with no inputs → FWD.

Source files
------------

// File: rtl/player_sprite_seq.sv
// Player sprite sequencer: chooses the pose and walk frame once per video frame and
// produces the registered per-pixel sprite ROM address and in-sprite flag.
module player_sprite_seq #(
  parameter int SPR_W        = 43,
  parameter int SPR_H        = 50,
  parameter int ANIM_DIV     = 6,
  parameter int SHOOT_FRAMES = 10
) (
  input  logic        vga_clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        shoot,
  input  logic [9:0]  PlayerX,
  input  logic [9:0]  PlayerY,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  output logic [1:0]  sprite_sel,
  output logic        anim_frame,
  output logic [12:0] rom_address,
  output logic        in_sprite
);

  typedef enum logic [1:0] {
    ST_FWD   = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2,
    ST_SHOOT = 2'd3
  } state_e;

  localparam logic [5:0]  ANIM_LAST = 6'(ANIM_DIV - 1);
  localparam logic [5:0]  HOLD_LOAD = 6'(SHOOT_FRAMES - 1);
  localparam logic [12:0] FRAME_OFS = 13'(SPR_W * SPR_H);

  state_e      state_q;
  state_e      state_d;
  logic [5:0]  hold_q;
  logic [5:0]  anim_cnt_q;
  logic        anim_q;
  logic        holding_s;
  logic        walking_s;

  logic [10:0] dx_s;
  logic [10:0] dy_s;
  logic        inside_s;
  logic [12:0] base_s;
  logic [12:0] addr_d;
  logic [12:0] addr_q;
  logic        in_sprite_q;

  assign holding_s = (state_q == ST_SHOOT) && (hold_q != 6'd0);
  assign walking_s = (state_q == ST_LEFT) || (state_q == ST_RIGHT);

  // Next pose: an active shoot hold wins, otherwise shoot > single direction > forward.
  always_comb begin
    state_d = ST_FWD;
    if (holding_s) begin
      state_d = ST_SHOOT;
    end else if (shoot) begin
      state_d = ST_SHOOT;
    end else if (move_left && !move_right) begin
      state_d = ST_LEFT;
    end else if (move_right && !move_left) begin
      state_d = ST_RIGHT;
    end else begin
      state_d = ST_FWD;
    end
  end

  // Pose FSM with shoot-hold and walk-animation counters, advanced only at frame_start.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_FWD;
      hold_q     <= 6'd0;
      anim_cnt_q <= 6'd0;
      anim_q     <= 1'b0;
    end else if (frame_start) begin
      state_q <= state_d;
      case (state_d)
        ST_SHOOT: begin
          hold_q     <= holding_s ? (hold_q - 6'd1) : HOLD_LOAD;
          anim_cnt_q <= 6'd0;
          anim_q     <= 1'b0;
        end
        ST_FWD: begin
          hold_q     <= 6'd0;
          anim_cnt_q <= 6'd0;
          anim_q     <= 1'b0;
        end
        default: begin
          hold_q <= 6'd0;
          // Walk counter runs across LEFT<->RIGHT turns and starts fresh on entry.
          if (!walking_s) begin
            anim_cnt_q <= 6'd0;
            anim_q     <= 1'b0;
          end else if (anim_cnt_q == ANIM_LAST) begin
            anim_cnt_q <= 6'd0;
            anim_q     <= ~anim_q;
          end else begin
            anim_cnt_q <= anim_cnt_q + 6'd1;
            anim_q     <= anim_q;
          end
        end
      endcase
    end else begin
      state_q    <= state_q;
      hold_q     <= hold_q;
      anim_cnt_q <= anim_cnt_q;
      anim_q     <= anim_q;
    end
  end

  // Box test and ROM address; negative offsets show up as the sign bit of the 11-bit difference.
  always_comb begin
    dx_s     = {1'b0, DrawX} - {1'b0, PlayerX};
    dy_s     = {1'b0, DrawY} - {1'b0, PlayerY};
    inside_s = blank && !dx_s[10] && !dy_s[10]
               && (dx_s < 11'(SPR_W)) && (dy_s < 11'(SPR_H));
    base_s   = ({3'b000, dy_s[9:0]} * 13'(SPR_W)) + {3'b000, dx_s[9:0]};
    if (!inside_s) begin
      addr_d = 13'd0;
    end else if (walking_s && anim_q) begin
      addr_d = base_s + FRAME_OFS;
    end else begin
      addr_d = base_s;
    end
  end

  // Pixel-path output registers, one cycle behind the pixel coordinates.
  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      addr_q      <= 13'd0;
      in_sprite_q <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      in_sprite_q <= inside_s;
    end
  end

  assign sprite_sel  = state_q;
  assign anim_frame  = anim_q;
  assign rom_address = addr_q;
  assign in_sprite   = in_sprite_q;

endmodule
